// File: rtl/nn_mlp_pkg.sv
// Shared helpers for the two-layer perceptron: config address map, accumulator
// sizing and default activation clip bounds.
package nn_mlp_pkg;

  localparam int XMIN_DEF = -127;
  localparam int XMAX_DEF = 127;

  // N products plus one bias term never overflow 2*DW + clog2(N) + 1 signed bits.
  function automatic int acc_w(input int dw, input int n);
    return 2 * dw + $clog2(n) + 1;
  endfunction

  function automatic int hid_w_addr(input int h, input int i, input int n_in);
    return h * n_in + i;
  endfunction

  function automatic int hid_b_addr(input int h, input int n_in, input int n_hid);
    return n_hid * n_in + h;
  endfunction

  function automatic int out_w_addr(input int h, input int n_in, input int n_hid);
    return n_hid * (n_in + 1) + h;
  endfunction

  function automatic int out_b_addr(input int n_in, input int n_hid);
    return n_hid * (n_in + 1) + n_hid;
  endfunction

  function automatic int ncfg(input int n_in, input int n_hid);
    return out_b_addr(n_in, n_hid) + 1;
  endfunction

endpackage

// File: rtl/nn_neuron_dot.sv
// One neuron: signed dot product + sign-extended bias, arithmetic (flooring) right
// shift, clip to [XMIN, XMAX]. Purely combinational, no flow control.
module nn_neuron_dot import nn_mlp_pkg::*; #(
  parameter int DW    = 8,
  parameter int N     = 4,
  parameter int SHIFT = 7,
  parameter int XMIN  = XMIN_DEF,
  parameter int XMAX  = XMAX_DEF,
  parameter int ACCW  = acc_w(DW, N)
) (
  input  logic [N*DW-1:0]          x,
  input  logic [N*DW-1:0]          w,
  input  logic signed [2*DW-1:0]   bias,
  output logic signed [DW-1:0]     y
);

  localparam logic signed [ACCW-1:0] LO_A = ACCW'(XMIN);
  localparam logic signed [ACCW-1:0] HI_A = ACCW'(XMAX);
  localparam logic signed [DW-1:0]   LO_Y = DW'(XMIN);
  localparam logic signed [DW-1:0]   HI_Y = DW'(XMAX);

  logic signed [DW-1:0]   xi;
  logic signed [DW-1:0]   wi;
  logic        [2*DW-1:0] prod;
  logic signed [ACCW-1:0] acc;
  logic signed [ACCW-1:0] sh;

  // Low 2*DW bits of a product are identical for signed and unsigned operands,
  // and a DW x DW signed product always fits in 2*DW bits.
  always_comb begin
    xi   = '0;
    wi   = '0;
    prod = '0;
    acc  = {{(ACCW-2*DW){bias[2*DW-1]}}, bias};
    for (int i = 0; i < N; i++) begin
      xi   = x[i*DW +: DW];
      wi   = w[i*DW +: DW];
      prod = {{DW{xi[DW-1]}}, xi} * {{DW{wi[DW-1]}}, wi};
      acc  = acc + {{(ACCW-2*DW){prod[2*DW-1]}}, prod};
    end
    sh = acc >>> SHIFT;
  end

  always_comb begin
    y = sh[DW-1:0];
    if (sh > HI_A)      y = HI_Y;
    else if (sh < LO_A) y = LO_Y;
  end

endmodule

// File: rtl/nn_mlp_pipe.sv
// Two-stage pipelined N_IN-N_HID-1 perceptron with run-time loadable weights/biases.
// Latency 2 cycles, 1 sample/cycle; each stage advances only when the next one can take it.
module nn_mlp_pipe import nn_mlp_pkg::*; #(
  parameter int DW    = 8,
  parameter int N_IN  = 4,
  parameter int N_HID = 2,
  parameter int SHIFT = 7,
  parameter int XMIN  = XMIN_DEF,
  parameter int XMAX  = XMAX_DEF,
  parameter int AW    = 6
) (
  input  logic                 clk,
  input  logic                 arst,
  input  logic [N_IN*DW-1:0]   in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [DW-1:0]        out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  input  logic                 cfg_we,
  input  logic [AW-1:0]        cfg_addr,
  input  logic [2*DW-1:0]      cfg_wdata
);

  localparam int NCFG = ncfg(N_IN, N_HID);
  localparam int NW   = N_HID * N_IN + N_HID;  // hidden weights, then output weights
  localparam int NB   = N_HID + 1;             // hidden biases, then output bias

  logic signed [DW-1:0]   w_q [NW];
  logic signed [DW-1:0]   w_d [NW];
  logic signed [2*DW-1:0] b_q [NB];
  logic signed [2*DW-1:0] b_d [NB];

  int   cfg_idx;
  logic cfg_wr;

  always_comb begin
    w_d     = w_q;
    b_d     = b_q;
    cfg_idx = int'(cfg_addr);
    cfg_wr  = cfg_we && (cfg_idx < NCFG);
    for (int h = 0; h < N_HID; h++) begin
      for (int i = 0; i < N_IN; i++) begin
        if (cfg_wr && cfg_idx == hid_w_addr(h, i, N_IN))
          w_d[h*N_IN + i] = cfg_wdata[DW-1:0];
      end
      if (cfg_wr && cfg_idx == hid_b_addr(h, N_IN, N_HID))
        b_d[h] = cfg_wdata;
      if (cfg_wr && cfg_idx == out_w_addr(h, N_IN, N_HID))
        w_d[N_HID*N_IN + h] = cfg_wdata[DW-1:0];
    end
    if (cfg_wr && cfg_idx == out_b_addr(N_IN, N_HID))
      b_d[N_HID] = cfg_wdata;
  end

  logic [N_IN*DW-1:0]  hw_pk [N_HID];
  logic [N_HID*DW-1:0] ow_pk;

  always_comb begin
    ow_pk = '0;
    for (int h = 0; h < N_HID; h++) begin
      hw_pk[h] = '0;
      for (int i = 0; i < N_IN; i++)
        hw_pk[h][i*DW +: DW] = w_q[h*N_IN + i];
      ow_pk[h*DW +: DW] = w_q[N_HID*N_IN + h];
    end
  end

  logic [N_HID*DW-1:0] h_y;
  logic [DW-1:0]       o_y;

  logic                v1_q, v1_d;
  logic                v2_q, v2_d;
  logic [N_HID*DW-1:0] h_q, h_d;
  logic [DW-1:0]       out_q, out_d;
  logic                en1, en2;

  for (genvar g = 0; g < N_HID; g++) begin : g_hid
    nn_neuron_dot #(
      .DW(DW), .N(N_IN), .SHIFT(SHIFT), .XMIN(XMIN), .XMAX(XMAX)
    ) u_hid (
      .x    (in_data),
      .w    (hw_pk[g]),
      .bias (b_q[g]),
      .y    (h_y[g*DW +: DW])
    );
  end

  nn_neuron_dot #(
    .DW(DW), .N(N_HID), .SHIFT(SHIFT), .XMIN(XMIN), .XMAX(XMAX)
  ) u_out (
    .x    (h_q),
    .w    (ow_pk),
    .bias (b_q[N_HID]),
    .y    (o_y)
  );

  // Stage data only moves when it carries a valid sample, so a bubble never
  // overwrites a held result.
  always_comb begin
    en2   = !v2_q || out_ready;
    en1   = !v1_q || en2;
    v1_d  = en1 ? in_valid : v1_q;
    h_d   = (en1 && in_valid) ? h_y : h_q;
    v2_d  = en2 ? v1_q : v2_q;
    out_d = (en2 && v1_q) ? o_y : out_q;
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      h_q   <= '0;
      out_q <= '0;
      w_q   <= '{default: '0};
      b_q   <= '{default: '0};
    end else begin
      v1_q  <= v1_d;
      v2_q  <= v2_d;
      h_q   <= h_d;
      out_q <= out_d;
      w_q   <= w_d;
      b_q   <= b_d;
    end
  end

  assign in_ready  = en1;
  assign out_valid = v2_q;
  assign out_data  = out_q;

endmodule

// File: tb/tb_nn_mlp_pipe.sv
// Directed bench for nn_mlp_pipe: hand-computed vectors, immediate assertions.
module tb_nn_mlp_pipe;

  localparam int DW    = 8;
  localparam int N_IN  = 4;
  localparam int N_HID = 2;
  localparam int AW    = 6;

  logic                clk = 1'b0;
  logic                arst;
  logic [N_IN*DW-1:0]  in_data;
  logic                in_valid;
  logic                in_ready;
  logic [DW-1:0]       out_data;
  logic                out_valid;
  logic                out_ready;
  logic                cfg_we;
  logic [AW-1:0]       cfg_addr;
  logic [2*DW-1:0]     cfg_wdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  nn_mlp_pipe #(.DW(DW), .N_IN(N_IN), .N_HID(N_HID), .AW(AW)) dut (
    .clk       (clk),
    .arst      (arst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pack4(input int a, input int b, input int c, input int d);
    return {d[7:0], c[7:0], b[7:0], a[7:0]};
  endfunction

  function automatic int sdata();
    return int'($signed(out_data));
  endfunction

  // All tasks enter and leave at a falling edge.
  task automatic cfg_write(input int addr, input int data);
    cfg_we    = 1'b1;
    cfg_addr  = addr[AW-1:0];
    cfg_wdata = data[2*DW-1:0];
    @(posedge clk);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic run_one(input string tag, input logic [31:0] d, input int exp);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = d;
    #1;
    check({tag, "_in_rdy"}, int'(in_ready), 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_vld_lat1"}, int'(out_valid), 0);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_vld_lat2"}, int'(out_valid), 1);
    check({tag, "_dat"}, sdata(), exp);
    @(posedge clk);
    @(negedge clk);
  endtask

  int sx0  [8] = '{10, 3, -3, 100, 127, -128, 7, 0};
  int sx1  [8] = '{20, 5, -5, 100, 127, -128, -9, 1};
  int sexp [8] = '{7, 1, -3, 50, 63, -64, -1, 0};

  initial begin
    int sent, recv, inflight, prev_dat;
    logic prev_stall, acc, fire;

    arst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    arst = 1'b0;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_data", sdata(), 0);

    run_one("zero_w", pack4(100, 50, 0, 0), 0);

    // h0 = x0/2, h1 = x1/2, out = (h0+h1)/2, all flooring
    cfg_write(0, 64);
    cfg_write(5, 64);
    cfg_write(10, 64);
    cfg_write(11, 64);
    run_one("basic", pack4(100, 50, 0, 0), 37);

    cfg_write(0, 127); cfg_write(1, 127); cfg_write(2, 127); cfg_write(3, 127);
    run_one("sat_hi", pack4(127, 127, 127, 127), 95);
    run_one("sat_lo", pack4(-127, -127, -127, -127), -96);

    cfg_write(1, 0); cfg_write(2, 0); cfg_write(3, 0); cfg_write(0, 64);
    run_one("neg100", pack4(-100, 0, 0, 0), -25);

    cfg_write(0, 1);
    run_one("floor_m1", pack4(-1, 0, 0, 0), -1);

    cfg_write(0, 64);
    sent = 0; recv = 0; inflight = 0; prev_stall = 1'b0; prev_dat = 0;
    for (int cyc = 0; cyc < 300 && recv < 8; cyc++) begin
      out_ready = (cyc < 4) ? 1'b0 : 1'($urandom_range(0, 1));
      in_valid  = (sent < 8);
      if (sent < 8) in_data = pack4(sx0[sent], sx1[sent], 0, 0);
      #1;
      if (prev_stall) begin
        check("hold_vld", int'(out_valid), 1);
        check("hold_dat", sdata(), prev_dat);
      end
      check("bp_in_rdy", int'(in_ready), (inflight == 2 && !out_ready) ? 0 : 1);
      acc  = in_valid && in_ready;
      fire = out_valid && out_ready;
      if (fire) begin
        check("stream_dat", sdata(), sexp[recv]);
        recv++;
      end
      prev_stall = out_valid && !out_ready;
      prev_dat   = sdata();
      if (acc) sent++;
      inflight = inflight + int'(acc) - int'(fire);
      @(posedge clk);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("stream_count", recv, 8);
    @(posedge clk);
    @(negedge clk);

    // Bias write lands on the same edge that accepts A, so A and B both see it.
    in_valid = 1'b1; in_data = pack4(10, 20, 0, 0);
    cfg_we = 1'b1; cfg_addr = 6'd12; cfg_wdata = 16'd128;
    @(posedge clk);
    @(negedge clk);
    cfg_we = 1'b0; in_data = pack4(3, 5, 0, 0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("race_a_vld", int'(out_valid), 1);
    check("race_a_dat", sdata(), 8);
    @(posedge clk);
    @(negedge clk);
    check("race_b_vld", int'(out_valid), 1);
    check("race_b_dat", sdata(), 2);
    @(posedge clk);
    @(negedge clk);

    cfg_write(13, 16'h4000);
    cfg_write(63, 16'h4000);
    run_one("bad_addr", pack4(10, 20, 0, 0), 8);

    out_ready = 1'b0;
    in_valid = 1'b1; in_data = pack4(100, 100, 0, 0);
    @(posedge clk);
    @(negedge clk);
    in_data = pack4(50, 50, 0, 0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    arst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    arst = 1'b0;
    out_ready = 1'b1;
    check("mid_rst_vld", int'(out_valid), 0);
    check("mid_rst_rdy", int'(in_ready), 1);
    check("mid_rst_dat", sdata(), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("mid_rst_drained", int'(out_valid), 0);
    run_one("post_rst", pack4(100, 50, 0, 0), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/nn_mlp_pipe.md
Name: nn_mlp_pipe

Overview:
Parametrised successor of the fixed 4-2-1 accelerator. It is a fully pipelined two-layer perceptron: N_IN signed inputs feed N_HID hidden neurons, whose outputs feed one output neuron. It has run-time loadable weights and biases, a valid/ready handshake on both sides and full-throughput backpressure. It sits between the sample source and the result consumer in the NeuroAccel datapath.

Parameters:
DW, 8, signed data and weight width
N_IN, 4, number of inputs (2..16)
N_HID, 2, number of hidden neurons (1..8)
SHIFT, 7, arithmetic right shift applied to each neuron's accumulator
XMIN, -127, lower clip bound of the activation
XMAX, 127, upper clip bound of the activation
AW, 6, config address width (must hold NCFG = N_HID*(N_IN+1)+N_HID+1)

Ports:
clk  in  1  clock, rising edge
arst  in  1  reset, synchronous, active-high
in_data  in  N_IN*DW  packed signed inputs; input i = bits [i*DW +: DW]
in_valid  in  1  input sample valid
in_ready  out  1  block accepts a sample this cycle
out_data  out  DW  signed network output
out_valid  out  1  out_data valid
out_ready  in  1  consumer accepts out_data
cfg_we  in  1  config write strobe
cfg_addr  in  AW  config register address
cfg_wdata  in  2*DW  write data; weights use the low DW bits, biases use all 2*DW bits (signed)

Behaviour:
- Reset: arst is sampled on the rising edge of clk only. On reset, stage valids are cleared and out_valid=0. out_data and the hidden registers are reset to 0. All weights and biases are reset to 0. in_ready=1 in the first cycle after reset. Any in-flight samples are discarded with no partial output.
- Neuron function: acc = sum(x_i*w_i) + sext(bias), computed at ACCW = 2*DW + clog2(N_IN) + 1 bits, signed. Then y = clip(acc >>> SHIFT, XMIN, XMAX). The shift is arithmetic and floors, so -1 >>> 7 = -1. No rounding.
- Stage 1: accepts in_data when in_valid && in_ready. Computes all N_HID hidden neurons in parallel and registers h[0..N_HID-1] with v1.
- Stage 2: the output neuron takes h as its inputs and registers out_data with v2. out_valid = v2.
- Latency: 2 cycles from the accept edge to out_valid=1 when there is no stall. Throughput is 1 sample/cycle.
- Flow control:
  - en2 = !v2 || out_ready
  - en1 = !v1 || en2
  - in_ready = en1, combinational, with no dependence on in_valid
  - A stage loads only when its enable is high; v1 and v2 update under the same enables.
- Output stability: out_data and out_valid hold stable while out_valid && !out_ready. No sample is dropped or duplicated under any backpressure pattern.
- Config map (addresses at or above NCFG are ignored; reads are not supported):
  - hidden weight (h, i) at h*N_IN + i
  - hidden bias h at N_HID*N_IN + h
  - output weight h at N_HID*(N_IN+1) + h
  - output bias at N_HID*(N_IN+1) + N_HID
- Config timing: a cfg write at edge t is visible to computations registered at edge t+1 and later. Samples already in a stage register keep their computed values. Writes during traffic are legal; there is no stall and no error.
- Simultaneous events: reset overrides config writes and handshakes in the same cycle.

Decomposition:
- Package nn_mlp_pkg: cfg address offset functions (hid_w_addr, hid_b_addr, out_w_addr, out_b_addr), the ACCW calculation, and the default clip bounds.
- Sub-module nn_neuron_dot: combinational, parametrised by DW/N/SHIFT/XMIN/XMAX. Performs dot product + bias + shift + clip. It is instantiated N_HID times in stage 1 and once in stage 2.
- Weight storage is a flat register array in the top level.

Test Plan:
- Reset: assert arst for 2 cycles mid-stream. Then out_valid=0, in_ready=1, all weights 0, and a following sample of any value outputs 0.
- Basic path (defaults), with h0 w=[64,0,0,0], h1 w=[0,64,0,0], out w=[64,64], all biases 0. Input [100,50,0,0] gives h=[50,25] and out_data=37, with out_valid exactly 2 cycles after accept.
- Saturation and floor:
  - All h0 weights 127 and input [127,127,127,127] gives h0 clipped to 127.
  - Input [-100,0,0,0] gives h0=-50.
  - Input [-1,0,0,0] with weight 1 gives -1.
- Backpressure: stream 8 samples back-to-back with out_ready toggled randomly. The output sequence matches the model in order, nothing is lost, in_ready=0 only when both stages are full and out_ready=0, and out_data is held while stalled.
- Config race: write out bias=128 while sample A is in stage 1 and sample B is arriving. A and B both see the new bias at stage 2. Check the +1 shift in out_data against the model. An address >= NCFG leaves all registers unchanged.
